// File: rtl/nlfsr_128_core.sv
// Grain-128-style NFSR coupled to a 128-bit LFSR, free-running PRNG.
// Optional runtime seed load enabled by macro NLFSR_SEED_LOAD_EN.
module nlfsr_128_core #(
   parameter logic [127:0] SEED_N =
      128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
   parameter logic [127:0] SEED_L =
      128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE,
   parameter int STEPS_PER_CLK = 1
) (
   input  logic         clk,
   input  logic         reset,
   output logic [127:0] prng_output
`ifdef NLFSR_SEED_LOAD_EN
   ,
   input  logic         load,
   input  logic [127:0] seed_n_in,
   input  logic [127:0] seed_l_in
`endif
);

   logic [127:0] n_q, n_d;
   logic [127:0] l_q, l_d;
   logic [127:0] n_s, l_s;
   logic         lf, nf;

   // Unrolled register steps, then load/lockup overrides
   always_comb begin
      n_s = n_q;
      l_s = l_q;
      lf  = 1'b0;
      nf  = 1'b0;
      for (int i = 0; i < STEPS_PER_CLK; i++) begin
         lf = l_s[0] ^ l_s[7] ^ l_s[38] ^ l_s[70]
            ^ l_s[81] ^ l_s[96];
         nf = l_s[0] ^ n_s[0] ^ n_s[26] ^ n_s[56]
            ^ n_s[91] ^ n_s[96]
            ^ (n_s[3]  & n_s[67])
            ^ (n_s[11] & n_s[13])
            ^ (n_s[17] & n_s[18])
            ^ (n_s[27] & n_s[59])
            ^ (n_s[40] & n_s[48])
            ^ (n_s[61] & n_s[65])
            ^ (n_s[68] & n_s[84]);
         l_s = {lf, l_s[127:1]};
         n_s = {nf, n_s[127:1]};
      end
      n_d = n_s;
      l_d = l_s;
`ifdef NLFSR_SEED_LOAD_EN
      if (load) begin
         n_d = seed_n_in;
         l_d = (seed_l_in == '0) ? SEED_L : seed_l_in;
      end else if (l_q == '0) begin
         n_d = SEED_N;
         l_d = SEED_L;
      end
`else
      if (l_q == '0) begin
         n_d = SEED_N;
         l_d = SEED_L;
      end
`endif
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         n_q <= SEED_N;
         l_q <= SEED_L;
      end else begin
         n_q <= n_d;
         l_q <= l_d;
      end
   end

   assign prng_output = n_q ^ l_q;

endmodule

// File: tb/tb_nlfsr_128_core.sv
// Testbench for nlfsr_128_core: queue-based bit model, 1- and 4-step
// instances, reset, shift, uniqueness, mid-run reset and seed load.
module tb_nlfsr_128_core;

   localparam logic [127:0] SN =
      128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] SL =
      128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
   localparam logic [127:0] RST_OUT =
      128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEE;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [127:0] out1, out4;
   logic         load = 1'b0;
   logic [127:0] seed_n_in = '0;
   logic [127:0] seed_l_in = '0;

   int checks = 0;
   int errors = 0;

   logic [127:0] hist[$];

   always #5 clk = ~clk;

   nlfsr_128_core #(.STEPS_PER_CLK(1)) dut1 (
      .clk(clk),
      .reset(reset),
      .prng_output(out1)
`ifdef NLFSR_SEED_LOAD_EN
      ,
      .load(load),
      .seed_n_in(seed_n_in),
      .seed_l_in(seed_l_in)
`endif
   );

   nlfsr_128_core #(.STEPS_PER_CLK(4)) dut4 (
      .clk(clk),
      .reset(reset),
      .prng_output(out4)
`ifdef NLFSR_SEED_LOAD_EN
      ,
      .load(load),
      .seed_n_in(seed_n_in),
      .seed_l_in(seed_l_in)
`endif
   );

   // Model: registers as bit queues, element i is bit i;
   // hist[s] is the output word after s single steps.
   task automatic gen_seq(input logic [127:0] n0,
                          input logic [127:0] l0,
                          input int cnt);
      bit nb[$];
      bit lb[$];
      bit lf, nf;
      logic [127:0] w;
      hist.delete();
      for (int i = 0; i < 128; i++) begin
         nb.push_back(n0[i]);
         lb.push_back(l0[i]);
      end
      for (int s = 0; s <= cnt; s++) begin
         for (int k = 0; k < 128; k++) w[k] = nb[k] ^ lb[k];
         hist.push_back(w);
         lf = lb[0] ^ lb[7] ^ lb[38] ^ lb[70] ^ lb[81] ^ lb[96];
         nf = lb[0] ^ nb[0] ^ nb[26] ^ nb[56] ^ nb[91] ^ nb[96];
         nf = nf ^ (nb[3] & nb[67]) ^ (nb[11] & nb[13]);
         nf = nf ^ (nb[17] & nb[18]) ^ (nb[27] & nb[59]);
         nf = nf ^ (nb[40] & nb[48]) ^ (nb[61] & nb[65]);
         nf = nf ^ (nb[68] & nb[84]);
         void'(lb.pop_front());
         lb.push_back(lf);
         void'(nb.pop_front());
         nb.push_back(nf);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int e = 0; e < 2; e++) begin
         tick();
         checks++;
         if (out1 !== RST_OUT) begin
            errors++;
            $display("FAIL reset1 edge %0d got %h exp %h",
                     e, out1, RST_OUT);
         end
         checks++;
         if (out4 !== RST_OUT) begin
            errors++;
            $display("FAIL reset4 edge %0d got %h exp %h",
                     e, out4, RST_OUT);
         end
      end
   endtask

   task automatic test_shift();
      logic [127:0] p1, p4;
      p1 = out1;
      p4 = out4;
      reset = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         tick();
         checks++;
         if (out1[126:0] !== p1[127:1]) begin
            errors++;
            $display("FAIL shift1 c%0d got %h prev %h", c, out1, p1);
         end
         checks++;
         if (out1 !== hist[c]) begin
            errors++;
            $display("FAIL model1 c%0d got %h exp %h", c, out1, hist[c]);
         end
         checks++;
         if (out4[123:0] !== p4[127:4]) begin
            errors++;
            $display("FAIL shift4 c%0d got %h prev %h", c, out4, p4);
         end
         checks++;
         if (out4 !== hist[4*c]) begin
            errors++;
            $display("FAIL model4 c%0d got %h exp %h",
                     c, out4, hist[4*c]);
         end
         p1 = out1;
         p4 = out4;
      end
   endtask

   task automatic test_unique_1000();
      bit seen[logic [127:0]];
      int reps, zeros, bad;
      reps = 0;
      zeros = 0;
      bad = 0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      seen[out1] = 1'b1;
      for (int c = 1; c <= 1000; c++) begin
         tick();
         if (seen.exists(out1)) reps++;
         seen[out1] = 1'b1;
         if (out1 == '0) zeros++;
         if (out1 !== hist[c]) bad++;
      end
      checks++;
      if (reps !== 0) begin
         errors++;
         $display("FAIL unique got %0d repeats exp 0", reps);
      end
      checks++;
      if (zeros !== 0) begin
         errors++;
         $display("FAIL nonzero got %0d zero words exp 0", zeros);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL model1000 got %0d mismatching words exp 0", bad);
      end
   endtask

   task automatic test_mid_reset();
      int skew;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      skew = $urandom_range(0, 3);
      for (int c = 1; c < 37 + skew; c++) tick();
      reset = 1'b0;
      tick();
      checks++;
      if (out1 !== RST_OUT) begin
         errors++;
         $display("FAIL midreset got %h exp %h", out1, RST_OUT);
      end
      reset = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         tick();
         checks++;
         if (out1 !== hist[c] || out4 !== hist[4*c]) begin
            errors++;
            $display("FAIL replay c%0d got %h/%h exp %h/%h",
                     c, out1, out4, hist[c], hist[4*c]);
         end
      end
   endtask

`ifdef NLFSR_SEED_LOAD_EN
   task automatic test_load();
      logic [127:0] exp;
      for (int c = 0; c < int'($urandom_range(1, 9)); c++) tick();
      seed_n_in = 128'h1;
      seed_l_in = 128'h0;
      load = 1'b1;
      tick();
      load = 1'b0;
      exp = 128'h1 ^ SL;
      checks++;
      if (out1 !== exp || out4 !== exp) begin
         errors++;
         $display("FAIL load got %h/%h exp %h", out1, out4, exp);
      end
      gen_seq(128'h1, SL, 8);
      tick();
      checks++;
      if (out1 !== hist[1] || out4 !== hist[4]) begin
         errors++;
         $display("FAIL resume got %h/%h exp %h/%h",
                  out1, out4, hist[1], hist[4]);
      end
   endtask
`endif

   initial begin
      gen_seq(SN, SL, 4004);
      test_reset();
      test_shift();
      test_unique_1000();
      test_mid_reset();
`ifdef NLFSR_SEED_LOAD_EN
      test_load();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
